sipo_frame_ctrl: RTL and testbench

Frame-level receive controller for the serial-in/parallel-out path. It hunts for a sync byte on a continuous one-bit-per-clock serial stream and then deserializes a fixed number of payload bytes. Each byte is presented on a valid/ready handshake to the downstream consumer. Overruns, frame boundaries and (optionally) parity errors are flagged, so the SIPO datapath is sequenced per frame rather than free-running.

---
 rtl/sipo_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-in/parallel-out receiver: hunts for SYNC_BYTE, then deserializes FRAME_LEN bytes onto a valid/ready port.
// Optional feature: define SIPO_PARITY_EN for a trailing even-parity bit per payload byte (9-bit slots).
module sipo_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       serial_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last,
    output logic       frame_start,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

`ifdef SIPO_PARITY_EN
    localparam logic [3:0]  SLOT_LAST = 4'd8;
    localparam int unsigned SHW       = 8;
`else
    localparam logic [3:0]  SLOT_LAST = 4'd7;
    localparam int unsigned SHW       = 7;
`endif
    localparam logic [3:0] LAST_BYTE = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

    state_t         state, state_nxt;
    logic [SHW-1:0] shreg;
    logic [3:0]     fill_cnt;
    logic [3:0]     bit_cnt;
    logic [3:0]     byte_cnt;
    logic [7:0]     shift_word;
    logic [7:0]     data_word;
    logic           sync_hit;
    logic           slot_done;
    logic           frame_done;
    logic           load;

    // One shift register serves as the sync window in HUNT and the payload shifter in RECV.
    assign shift_word = {shreg[6:0], serial_in};
`ifdef SIPO_PARITY_EN
    assign data_word  = shreg[7:0];
`else
    assign data_word  = shift_word;
`endif

    assign sync_hit   = enable && (state == HUNT) && (fill_cnt >= 4'd7) && (shift_word == SYNC_BYTE);
    assign slot_done  = enable && (state == RECV) && (bit_cnt == SLOT_LAST);
    assign frame_done = slot_done && (byte_cnt == LAST_BYTE);
    assign load       = slot_done && (!byte_valid || byte_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = HUNT;
                HUNT:    if (sync_hit) state_nxt = RECV;
                RECV:    if (frame_done) state_nxt = HUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            fill_cnt    <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            frame_start <= 1'b0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            byte_last   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_start <= sync_hit;

            if (!enable || state == IDLE) begin
                shreg    <= '0;
                fill_cnt <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (state == HUNT) begin
                shreg <= shift_word[SHW-1:0];
                if (fill_cnt != 4'd8) fill_cnt <= fill_cnt + 4'd1;
                if (sync_hit) begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
            end else begin
                if (bit_cnt < 4'd8) shreg <= shift_word[SHW-1:0];
                if (slot_done) begin
                    bit_cnt  <= '0;
                    byte_cnt <= byte_cnt + 4'd1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (frame_done) begin
                    shreg    <= '0;
                    fill_cnt <= '0;
                end
            end

            if (!enable)                    overrun <= 1'b0;
            else if (slot_done && !load)    overrun <= 1'b1;

            // A pending byte survives enable going low; only acceptance or reset retires it.
            if (load) begin
                byte_out   <= data_word;
                byte_valid <= 1'b1;
                byte_last  <= (byte_cnt == LAST_BYTE);
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)                                         parity_err <= 1'b0;
        else if (!enable)                                parity_err <= 1'b0;
        else if (slot_done && ((^shreg) ^ serial_in))    parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl (default SYNC_BYTE=A5, FRAME_LEN=4).
module tb_sipo_frame_ctrl;

`ifdef SIPO_PARITY_EN
    localparam int SLOT = 9;
`else
    localparam int SLOT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       serial_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;
    logic       frame_start;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_data [0:63];
    logic       rx_last [0:63];
    int         rx_cyc  [0:63];
    int         rx_n = 0;
    int         fs_n = 0;
    int         cyc  = 0;

    sipo_frame_ctrl #(.SYNC_BYTE(8'hA5), .FRAME_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .serial_in  (serial_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .frame_start(frame_start),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every accepted byte and every frame_start pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready && rx_n < 64) begin
            rx_data[rx_n] = byte_out;
            rx_last[rx_n] = byte_last;
            rx_cyc[rx_n]  = cyc;
            rx_n++;
        end
        if (!rst && frame_start) fs_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ready_at_last, input logic bad_par);
        logic bt;
        for (int i = 0; i < SLOT; i++) begin
            bt = (i < 8) ? b[7 - i] : ((^b) ^ bad_par);
            if (i == SLOT - 1 && ready_at_last) byte_ready = 1'b1;
            send_bit(bt);
        end
    endtask

    int rx0;
    int fs0;
    logic [7:0] exp_bytes [0:3];

    initial begin
        rst = 1'b1; enable = 1'b0; byte_ready = 1'b0; serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_valid", byte_valid, 0);
        check("rst_last", byte_last, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_busy", busy, 0);

        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        enable = 1'b1;
        @(posedge clk); #1;
        check("hunt_busy", busy, 1);

        // Frame 1: 5A decoy then A5 sync, payload 11 22 33 44, consumer always ready
        byte_ready = 1'b1;
        fs0 = fs_n; rx0 = rx_n;
        send_raw(8'h5A);
        check("no_false_sync", frame_start, 0);
        send_raw(8'hA5);
        check("sync_frame_start", frame_start, 1);
        check("sync_busy", busy, 1);
        send_byte(8'h11, 1'b0, 1'b0);
        check("f1_b0_valid", byte_valid, 1);
        check("f1_b0_data", byte_out, 8'h11);
        check("f1_b0_last", byte_last, 0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        check("f1_b3_data", byte_out, 8'h44);
        check("f1_b3_last", byte_last, 1);
        send_bit(1'b0); send_bit(1'b0);
        check("f1_valid_cleared", byte_valid, 0);
        check("f1_fs_count", fs_n - fs0, 1);
        check("f1_rx_count", rx_n - rx0, 4);
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f1_rx%0d_data", i), rx_data[rx0 + i], exp_bytes[i]);
            check($sformatf("f1_rx%0d_last", i), rx_last[rx0 + i], (i == 3) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("f1_spacing%0d", i), rx_cyc[rx0 + i + 1] - rx_cyc[rx0 + i], SLOT);
        check("f1_overrun", overrun, 0);
        check("f1_parity_err", parity_err, 0);

        // Frame 2: stalled consumer causes overrun; ready rises on a completion edge
        byte_ready = 1'b0;
        rx0 = rx_n;
        send_raw(8'hA5);
        send_byte(8'h11, 1'b0, 1'b0);
        check("f2_b0_data", byte_out, 8'h11);
        check("f2_b0_overrun", overrun, 0);
        send_byte(8'h22, 1'b0, 1'b0);
        check("f2_overrun_set", overrun, 1);
        check("f2_held_data", byte_out, 8'h11);
        check("f2_held_valid", byte_valid, 1);
        send_byte(8'h33, 1'b1, 1'b0);
        check("f2_edge_load_data", byte_out, 8'h33);
        check("f2_edge_load_valid", byte_valid, 1);
        check("f2_overrun_unchanged", overrun, 1);
        check("f2_held_byte_delivered", rx_data[rx0], 8'h11);
        send_byte(8'h44, 1'b0, 1'b0);
        check("f2_b3_last", byte_last, 1);
        send_bit(1'b0); send_bit(1'b0);
        check("f2_rx_count", rx_n - rx0, 3);
        check("f2_rx1_data", rx_data[rx0 + 1], 8'h33);
        check("f2_rx2_data", rx_data[rx0 + 2], 8'h44);
        check("f2_rx2_last", rx_last[rx0 + 2], 1);

        // Frame 3: abort after 4 payload bits by dropping enable, then a clean frame
        rx0 = rx_n; fs0 = fs_n;
        send_raw(8'hA5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        enable = 1'b0;
        @(posedge clk); #1;
        check("dis_busy", busy, 0);
        check("dis_overrun_clear", overrun, 0);
        check("dis_valid", byte_valid, 0);
        enable = 1'b1; serial_in = 1'b1;
        @(posedge clk); #1;
        check("reen_busy", busy, 1);
        send_raw(8'hA5);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h88, 1'b0, 1'b0);
        send_bit(1'b0); send_bit(1'b0);
        check("f3_fs_count", fs_n - fs0, 2);
        check("f3_rx_count", rx_n - rx0, 4);
        exp_bytes[0] = 8'h55; exp_bytes[1] = 8'h66; exp_bytes[2] = 8'h77; exp_bytes[3] = 8'h88;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f3_rx%0d_data", i), rx_data[rx0 + i], exp_bytes[i]);
            check($sformatf("f3_rx%0d_last", i), rx_last[rx0 + i], (i == 3) ? 1 : 0);
        end
        check("f3_overrun", overrun, 0);
        check("f3_parity_err", parity_err, 0);

`ifdef SIPO_PARITY_EN
        // Frame 4: first byte carries a wrong parity bit
        send_raw(8'hA5);
        send_byte(8'h03, 1'b0, 1'b1);
        check("par_bad_data", byte_out, 8'h03);
        check("par_bad_valid", byte_valid, 1);
        check("par_err_set", parity_err, 1);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        check("par_err_sticky", parity_err, 1);
        send_bit(1'b0);
`endif

        // Reset mid-frame loses the pending byte
        byte_ready = 1'b0;
        send_raw(8'hA5);
        send_byte(8'h99, 1'b0, 1'b0);
        check("pre_rst_valid", byte_valid, 1);
        check("pre_rst_data", byte_out, 8'h99);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", byte_valid, 0);
        check("mid_rst_data", byte_out, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_parity_err", parity_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
